pll_cfg_sequencer: RTL
======================

Name: pll_cfg_sequencer

Overview:
Downstream consumer of the SPI frame decoder in the PLL map path. Takes each decoded configuration command (read/write/pllen/ratio) and applies it to the PLL in a safe order: disable, settle, load ratio, enable, wait for lock with timeout. Returns a status snapshot for read-back.

Parameters:
RATIO_W, 10, width of the PLL feedback ratio field
RESET_RATIO, 6, ratio driven out of reset
SETTLE_CYCLES, 16, clk cycles held disabled before a new ratio is applied
LOCK_TIMEOUT, 4096, clk cycles allowed for lock after enable
SYNC_STAGES, 2, synchronizer depth for pll_lock

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
cfg_valid  in  1  one-cycle strobe; command fields valid
cfg_read  in  1  request status snapshot
cfg_write  in  1  request configuration update
cfg_pllen  in  1  requested PLL enable
cfg_ratio  in  RATIO_W  requested ratio
pll_lock  in  1  raw lock from PLL, asynchronous to clk
pll_en  out  1  PLL enable
pll_ratio  out  RATIO_W  PLL ratio
busy  out  1  sequence in progress
done  out  1  one-cycle pulse when a command completes
status_valid  out  1  one-cycle pulse; status_data valid
status_data  out  16  {busy,err_overrun,err_ratio,err_timeout,lock_s,pll_en,pll_ratio}; ratio in [9:0]

Behaviour:
- Reset values: pll_en=0, pll_ratio=RESET_RATIO, busy=0, done=0, status_valid=0, status_data=0, all error bits=0, FSM=IDLE.
- pll_lock passes through SYNC_STAGES flops to lock_s. All decisions use lock_s.
- FSM states: IDLE, DISABLE, SETTLE, APPLY, ENABLE, WAIT_LOCK, REPORT. busy=1 in every state except IDLE.
- IDLE, cfg_valid with cfg_write=1:
  - cfg_ratio==0: reject. Set err_ratio, no output change. Go to REPORT if cfg_read, else pulse done next cycle.
  - Otherwise go to DISABLE.
- IDLE, cfg_valid with only cfg_read: go to REPORT.
- IDLE, cfg_valid with neither bit: ignored, no done.
- DISABLE: pll_en<=0. Next state SETTLE; counter loads SETTLE_CYCLES-1.
- SETTLE: count down. At 0 go to APPLY.
- APPLY: pll_ratio<=latched ratio. If latched pllen=1 go to ENABLE; else finish (REPORT if read latched, else done).
- ENABLE: pll_en<=1, timeout counter cleared. Next state WAIT_LOCK.
- WAIT_LOCK:
  - lock_s=1: finish.
  - Counter reaches LOCK_TIMEOUT-1 with no lock: set err_timeout, leave pll_en=1, finish.
- REPORT: status_data<=snapshot with busy field=0. status_valid=1 for one cycle. err_* cleared in the same cycle, so the snapshot carries the pre-clear values. done pulses the same cycle. Return to IDLE.
- Completion without read: done pulses the cycle the FSM returns to IDLE.
- Command latching: fields are latched on accept. Later cfg_* changes do not affect a running sequence.
- cfg_valid while busy: command dropped, err_overrun set. If it arrives in the same cycle as an err_* clear in REPORT, set wins.
- Write with pllen=0 and same ratio: full sequence still runs; pll_en ends at 0.
- Lock loss while IDLE: reflected only in lock_s/status; no automatic retry.
- Reset mid-sequence: immediate return to reset values.
- Counter widths: $clog2 of the larger of SETTLE_CYCLES and LOCK_TIMEOUT; no wrap beyond the terminal count.

Decomposition:
- pllMap_pkg gains:
  - fsm state enum
  - status_t packed struct (16 bits, layout above)
  - constant STATUS_W=16
- The synchronizer is one natural sub-module: pll_lock_sync, parameterized SYNC_STAGES, instantiated once.

Test Plan:
- Reset release with no command: pll_en=0, pll_ratio=6, busy=0, status_valid never pulses.
- Write pllen=1, ratio=11, lock raised 50 cycles after pll_en rises:
  - pll_en low for exactly 16 cycles before ratio changes to 11.
  - pll_en=1, done pulses SYNC_STAGES+1 cycles after the lock edge.
  - err_timeout=0.
- Write+read, ratio=11, lock held 0: after 4096 WAIT_LOCK cycles, status_valid pulses with status_data[12]=1 and [9:0]=11. A following read returns bit12=0.
- Write ratio=0 then read: pll_ratio unchanged (6), first status bit13=1.
- Second cfg_valid during SETTLE: command ignored, pll_ratio from the first command. Next read shows bit14=1.
- Assert rst during WAIT_LOCK: outputs return to reset values asynchronously. After release, IDLE accepts a new write normally.

Source files
------------

// File: rtl/pllMap_pkg.sv
// Shared types for the PLL map path: sequencer states, the read-back status word
// and a counter-sizing helper.
package pllMap_pkg;

  localparam int STATUS_W       = 16;
  localparam int STATUS_RATIO_W = STATUS_W - 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DISABLE,
    ST_SETTLE,
    ST_APPLY,
    ST_ENABLE,
    ST_WAIT_LOCK,
    ST_REPORT
  } state_t;

  typedef struct packed {
    logic                      busy;
    logic                      err_overrun;
    logic                      err_ratio;
    logic                      err_timeout;
    logic                      lock_s;
    logic                      pll_en;
    logic [STATUS_RATIO_W-1:0] ratio;
  } status_t;

  // One counter serves both the settle and the lock-timeout phases.
  function automatic int cnt_width(input int a, input int b);
    int w;
    w = (a > b) ? $clog2(a) : $clog2(b);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-flop synchronizer bringing the PLL's raw lock indication into the clk domain.
module pll_lock_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_lock,
  output logic o_lock_s
);

  logic [SYNC_STAGES-1:0] r_sync;

  // NOTE: clocked state uses non-blocking assignments so every stage samples the
  // previous stage's old value; blocking here would collapse the chain to one flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= i_lock;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_lock_s = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/pll_cfg_sequencer.sv
// Applies decoded PLL configuration commands in a safe order (disable, settle,
// load ratio, enable, wait for lock) and returns a status snapshot on request.
module pll_cfg_sequencer
  import pllMap_pkg::*;
#(
  parameter int RATIO_W       = 10,
  parameter int RESET_RATIO   = 6,
  parameter int SETTLE_CYCLES = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  input  logic                cfg_read,
  input  logic                cfg_write,
  input  logic                cfg_pllen,
  input  logic [RATIO_W-1:0]  cfg_ratio,
  input  logic                pll_lock,
  output logic                pll_en,
  output logic [RATIO_W-1:0]  pll_ratio,
  output logic                busy,
  output logic                done,
  output logic                status_valid,
  output logic [STATUS_W-1:0] status_data
);

  localparam int CNT_W = cnt_width(SETTLE_CYCLES, LOCK_TIMEOUT);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;

  logic               r_cmd_read, r_cmd_pllen;
  logic [RATIO_W-1:0] r_cmd_ratio;
  logic               r_pll_en;
  logic [RATIO_W-1:0] r_pll_ratio;
  logic               r_err_overrun, r_err_ratio, r_err_timeout;
  logic               r_done, r_status_valid;
  status_t            r_status_data;

  logic    w_lock_s, w_busy, w_overrun;
  logic    w_accept, w_set_err_ratio, w_set_err_timeout;
  logic    w_pll_en_clr, w_pll_en_set, w_ratio_load;
  logic    w_done_nxt, w_report;
  state_t  w_finish_state;
  status_t w_snapshot;

  pll_lock_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk      (clk),
    .rst      (rst),
    .i_lock   (pll_lock),
    .o_lock_s (w_lock_s)
  );

  assign w_busy         = (r_state != ST_IDLE);
  assign w_overrun      = cfg_valid && w_busy;
  assign w_finish_state = r_cmd_read ? ST_REPORT : ST_IDLE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default before the case statement;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_accept          = 1'b0;
    w_set_err_ratio   = 1'b0;
    w_set_err_timeout = 1'b0;
    w_pll_en_clr      = 1'b0;
    w_pll_en_set      = 1'b0;
    w_ratio_load      = 1'b0;
    w_done_nxt        = 1'b0;
    w_report          = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (cfg_valid && cfg_write) begin
          if (cfg_ratio == '0) begin
            w_set_err_ratio = 1'b1;
            if (cfg_read) w_state_nxt = ST_REPORT;
            else          w_done_nxt  = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = ST_DISABLE;
          end
        end else if (cfg_valid && cfg_read) begin
          w_state_nxt = ST_REPORT;
        end
      end
      ST_DISABLE: begin
        w_pll_en_clr = 1'b1;
        w_cnt_nxt    = CNT_W'(SETTLE_CYCLES - 1);
        w_state_nxt  = ST_SETTLE;
      end
      ST_SETTLE: begin
        // The APPLY cycle is the last disabled cycle, so leave as the count hits 0.
        if (r_cnt <= CNT_W'(1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_APPLY;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_APPLY: begin
        w_ratio_load = 1'b1;
        if (r_cmd_pllen) begin
          w_state_nxt = ST_ENABLE;
        end else begin
          w_state_nxt = w_finish_state;
          w_done_nxt  = !r_cmd_read;
        end
      end
      ST_ENABLE: begin
        w_pll_en_set = 1'b1;
        w_cnt_nxt    = '0;
        w_state_nxt  = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_nxt = w_finish_state;
          w_done_nxt  = !r_cmd_read;
        end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          w_set_err_timeout = 1'b1;
          w_state_nxt       = w_finish_state;
          w_done_nxt        = !r_cmd_read;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_REPORT: begin
        w_report    = 1'b1;
        w_done_nxt  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_snapshot             = '0;
    w_snapshot.err_overrun = r_err_overrun;
    w_snapshot.err_ratio   = r_err_ratio;
    w_snapshot.err_timeout = r_err_timeout;
    w_snapshot.lock_s      = w_lock_s;
    w_snapshot.pll_en      = r_pll_en;
    w_snapshot.ratio       = STATUS_RATIO_W'(r_pll_ratio);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_read     <= 1'b0;
      r_cmd_pllen    <= 1'b0;
      r_cmd_ratio    <= '0;
      r_pll_en       <= 1'b0;
      r_pll_ratio    <= RATIO_W'(RESET_RATIO);
      r_err_overrun  <= 1'b0;
      r_err_ratio    <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_done         <= 1'b0;
      r_status_valid <= 1'b0;
      r_status_data  <= '0;
    end else begin
      r_done         <= w_done_nxt;
      r_status_valid <= w_report;
      if (w_accept) begin
        r_cmd_read  <= cfg_read;
        r_cmd_pllen <= cfg_pllen;
        r_cmd_ratio <= cfg_ratio;
      end
      if (w_pll_en_clr)      r_pll_en <= 1'b0;
      else if (w_pll_en_set) r_pll_en <= 1'b1;
      if (w_ratio_load) r_pll_ratio <= r_cmd_ratio;
      if (w_report) r_status_data <= w_snapshot;
      // A report clears the error bits; a fresh error in the same cycle survives.
      r_err_overrun <= (r_err_overrun && !w_report) || w_overrun;
      r_err_ratio   <= (r_err_ratio   && !w_report) || w_set_err_ratio;
      r_err_timeout <= (r_err_timeout && !w_report) || w_set_err_timeout;
    end
  end

  assign pll_en       = r_pll_en;
  assign pll_ratio    = r_pll_ratio;
  assign busy         = w_busy;
  assign done         = r_done;
  assign status_valid = r_status_valid;
  assign status_data  = r_status_data;

endmodule
